// File: rtl/tpu_isa_pkg.sv
// Shared ISA definitions for the tiny processor pipeline.
// Holds the opcode encodings, instruction field positions, default widths
// and the fetch-stage state type.
package tpu_isa_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 8;

  localparam logic [1:0] OP_ALU  = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_MOVC = 2'b10;
  localparam logic [1:0] OP_JMP  = 2'b11;

  localparam int OPC_MSB     = 7;
  localparam int OPC_LSB     = 6;
  localparam int JMP_TGT_MSB = 5;
  localparam int JMP_TGT_LSB = 0;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_t;

  // True when the instruction word carries the JMP opcode.
  function automatic logic is_jmp(input logic [7:0] instr);
    return instr[OPC_MSB:OPC_LSB] == OP_JMP;
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter register for the fetch stage.
// A load (jump) takes priority over an increment; the increment wraps
// naturally at 2^ADDR_W.
module fetch_pc #(
  parameter int                ADDR_W   = 6,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              inc_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next PC: jump target, sequential successor, or hold.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  // PC register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage sitting after the combinational program ROM.
// Drives the ROM address from the PC, resolves JMP locally and hands every
// other instruction downstream through a one-entry valid/ready register.
// Optional feature macro: HALT_DETECT_EN (self-loop JMP stops fetching).
module fetch_unit
  import tpu_isa_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              run_i,
  output logic [ADDR_W-1:0] addr_o,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] instr_o,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [ADDR_W-1:0] instr_pc_o,
  output logic              halted_o
);

  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] pc;
  logic              slot_free;
  logic              fetch_en;
  logic              data_is_jmp;
  logic [ADDR_W-1:0] jmp_tgt;

  assign slot_free   = !valid_q || instr_ready_i;
  assign data_is_jmp = is_jmp(data_i[7:0]);
  assign jmp_tgt     = ADDR_W'(data_i[JMP_TGT_MSB:JMP_TGT_LSB]);

`ifdef HALT_DETECT_EN
  localparam logic [0:0] ST_FETCH = 1'(FETCH);
  localparam logic [0:0] ST_HALT  = 1'(HALT);

  logic [0:0] state_q, state_d;

  assign fetch_en = run_i && slot_free && (state_q == ST_FETCH);

  // A fetched JMP back onto its own address parks the stage in HALT for good.
  always_comb begin
    state_d = state_q;
    if (fetch_en && data_is_jmp && (jmp_tgt == pc)) begin
      state_d = ST_HALT;
    end
  end

  // State register; only reset leaves HALT.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  assign halted_o = (state_q == ST_HALT);
`else
  assign fetch_en = run_i && slot_free;
  assign halted_o = 1'b0;
`endif

  // Output slot: load a non-JMP fetch, otherwise drain an accepted entry.
  // A JMP fetch implies the slot was free, so it falls into the drain path
  // and produces the one-cycle bubble.
  always_comb begin
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    if (fetch_en && !data_is_jmp) begin
      instr_d    = data_i;
      instr_pc_d = pc;
      valid_d    = 1'b1;
    end else if (valid_q && instr_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Output slot registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  fetch_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .inc_i      (fetch_en && !data_is_jmp),
    .load_i     (fetch_en && data_is_jmp),
    .load_val_i (jmp_tgt),
    .pc_o       (pc)
  );

  assign addr_o        = pc;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign instr_valid_o = valid_q;

endmodule
